fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 523 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding imem request at a time, buffers
// the returned word in a single output register and follows redirects from execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_fault,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        out_free;
  logic        pc_misaligned;
  logic        req_hs;
  logic        load;
  logic        load_fault;

  // Handshakes: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
  // valid never depends on ready. Responses have no backpressure, and inst transfers
  // downstream on an edge where inst_valid && inst_ready.
  assign out_free       = !inst_valid || inst_ready;
  assign pc_misaligned  = (pc[1:0] != 2'b00);
  assign imem_req_valid = (state == S_REQ) && !pc_misaligned && out_free;
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign dbg_state      = state;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    load       = 1'b0;
    load_fault = 1'b0;
    if (redirect_valid) begin
      // Redirect beats everything; remember whether a response is still in flight.
      pc_nxt = redirect_pc;
      case (state)
        S_WAIT, S_DRAIN: state_nxt = imem_resp_valid ? S_REQ : S_DRAIN;
        S_REQ:           state_nxt = req_hs ? S_DRAIN : S_REQ;
        default:         state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE: state_nxt = S_REQ;
        S_REQ: begin
          if (out_free && pc_misaligned) begin
            load       = 1'b1;
            load_fault = 1'b1;
            state_nxt  = S_HALT;
          end else if (req_hs) begin
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            load = 1'b1;
            if (imem_resp_fault) begin
              load_fault = 1'b1;
              state_nxt  = S_HALT;
            end else begin
              pc_nxt    = pc + 32'd4;
              state_nxt = S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (imem_resp_valid) state_nxt = S_REQ;
        end
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      inst_fault <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (redirect_valid) begin
        inst_valid <= 1'b0;
      end else if (load) begin
        inst_valid <= 1'b1;
        inst       <= load_fault ? 32'd0 : imem_resp_data;
        inst_pc    <= pc;
        inst_fault <= load_fault;
      end else if (inst_valid && inst_ready) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a random-latency memory responder, a program-order stream
// scoreboard and directed scenario tasks.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_fault;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int fail_count = 0;

  int          lat_min = 0;
  int          lat_max = 0;
  bit          rdy_rand = 1'b0;
  bit          fault_en = 1'b0;
  logic [31:0] fault_addr = 32'd0;
  logic [31:0] mem_key = 32'd0;
  bit          inject_rsp = 1'b0;
  logic        rsp_drive = 1'b0;
  logic [31:0] rsp_data = 32'd0;
  logic        rsp_fault = 1'b0;
  bit          pending = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          countdown = 0;
  bit          s_hs = 1'b0;
  logic [31:0] s_addr = 32'd0;

  logic [31:0] exp_pc = RST_PC;
  bit          halted = 1'b0;
  int          consumed = 0;
  logic        exp_f;
  logic [31:0] exp_i;

  assign imem_resp_valid = rsp_drive | inject_rsp;
  assign imem_resp_data  = inject_rsp ? 32'hDEAD_BEEF : rsp_data;
  assign imem_resp_fault = inject_rsp ? 1'b0 : rsp_fault;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_fault(imem_resp_fault),
    .inst(inst), .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_fault(inst_fault), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_key;
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
    return fault_en && (a == fault_addr);
  endfunction

  // Program-order model: after reset or a redirect to T the consumed stream is
  // T, T+4, ... up to and including the first faulting address, then nothing.
  always @(negedge clk) begin
    s_hs   = rst_n && imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    if (!rst_n) begin
      exp_pc = RST_PC;
      halted = 1'b0;
    end else if (redirect_valid) begin
      exp_pc = redirect_pc;
      halted = 1'b0;
    end else begin
      if (halted) begin
        tests_run++;
        if (imem_req_valid !== 1'b0) begin
          fail_count++;
          $display("FAIL halt_no_req: imem_req_valid=%b required 0", imem_req_valid);
        end
      end
      if (inst_valid && inst_ready) begin
        tests_run++;
        consumed++;
        if (halted) begin
          fail_count++;
          $display("FAIL consume_after_halt: got pc=%h, no instruction required", inst_pc);
        end else begin
          exp_f = (exp_pc[1:0] != 2'b00) || is_fault(exp_pc);
          exp_i = exp_f ? 32'd0 : mem_data(exp_pc);
          if (inst_pc !== exp_pc || inst !== exp_i || inst_fault !== exp_f) begin
            fail_count++;
            $display("FAIL stream: got pc=%h inst=%h fault=%b required pc=%h inst=%h fault=%b",
                     inst_pc, inst, inst_fault, exp_pc, exp_i, exp_f);
          end
          if (exp_f) halted = 1'b1;
          else exp_pc = exp_pc + 32'd4;
        end
      end
    end
    if (s_hs) begin
      tests_run++;
      if (s_addr[1:0] !== 2'b00) begin
        fail_count++;
        $display("FAIL req_align: addr=%h required word aligned", s_addr);
      end
    end
  end

  // Memory responder: one response per accepted request after a random delay.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pending   = 1'b0;
        rsp_drive = 1'b0;
      end else begin
        if (rsp_drive) pending = 1'b0;
        if (s_hs) begin
          tests_run++;
          if (pending) begin
            fail_count++;
            $display("FAIL one_outstanding: new request at %h while %h pending", s_addr, pend_addr);
          end
          pending   = 1'b1;
          pend_addr = s_addr;
          countdown = $urandom_range(lat_max, lat_min);
        end
        rsp_drive = 1'b0;
        rsp_fault = 1'b0;
        rsp_data  = $urandom;
        if (pending) begin
          if (countdown == 0) begin
            rsp_drive = 1'b1;
            rsp_fault = is_fault(pend_addr);
            if (!rsp_fault) rsp_data = mem_data(pend_addr);
          end else begin
            countdown--;
          end
        end
      end
      imem_req_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic wait_valid(input int max, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      n++;
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_hs(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0 || inst_fault !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_outputs: valid=%b inst=%h pc=%h fault=%b required all 0",
               inst_valid, inst, inst_pc, inst_fault);
    end
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_req: imem_req_valid=%b required 0", imem_req_valid);
    end
    // Release with a stray response present while the unit is still idle.
    @(posedge clk);
    #2;
    rst_n      = 1'b1;
    inject_rsp = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL first_req_early: imem_req_valid=%b required 0", imem_req_valid);
    end
    @(posedge clk);
    #2;
    inject_rsp = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || inst_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL first_req: valid=%b addr=%h inst_valid=%b required 1 %h 0",
               imem_req_valid, imem_req_addr, inst_valid, RST_PC);
    end
  endtask

  task automatic test_sequential;
    bit ok;
    int n;
    for (int k = 0; k < 4; k++) begin
      wait_valid(10, ok, n);
      tests_run++;
      if (!ok || inst_pc !== RST_PC + 32'(4 * k) || inst !== mem_data(RST_PC + 32'(4 * k)) || inst_fault !== 1'b0) begin
        fail_count++;
        $display("FAIL seq_inst: ok=%b pc=%h inst=%h fault=%b required pc=%h inst=%h fault=0",
                 ok, inst_pc, inst, inst_fault, RST_PC + 32'(4 * k), mem_data(RST_PC + 32'(4 * k)));
      end
      if (k > 0) begin
        tests_run++;
        if (n != 2) begin
          fail_count++;
          $display("FAIL seq_rate: gap=%0d cycles required 2", n);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] cap_inst, cap_pc;
    logic [2:0]  cap_state;
    bit ok;
    int n;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
    inst_ready = 1'b0;
    cap_inst   = inst;
    cap_pc     = inst_pc;
    cap_state  = dbg_state;
    tests_run++;
    if (!ok) begin
      fail_count++;
      $display("FAIL bp_timeout: no instruction within 10 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b1 || inst !== cap_inst || inst_pc !== cap_pc || imem_req_valid !== 1'b0 ||
          dbg_state !== cap_state) begin
        fail_count++;
        $display("FAIL bp_hold: valid=%b inst=%h pc=%h req=%b state=%0d required 1 %h %h 0 %0d",
                 inst_valid, inst, inst_pc, imem_req_valid, dbg_state, cap_inst, cap_pc, cap_state);
      end
    end
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    @(negedge clk);
    wait_valid(10, ok, n);
    tests_run++;
    if (!ok || inst_pc !== cap_pc + 32'd4) begin
      fail_count++;
      $display("FAIL bp_next: ok=%b pc=%h required %h", ok, inst_pc, cap_pc + 32'd4);
    end
  endtask

  task automatic test_redirect_wait;
    bit ok;
    int n;
    lat_min = 2;
    lat_max = 2;
    wait_hs(20, ok);
    pulse_redirect(32'h100);
    @(negedge clk);
    tests_run++;
    if (!ok || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL rdw_drain: ok=%b inst_valid=%b req=%b required 1 0 0", ok, inst_valid, imem_req_valid);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL rdw_drain_hold: req=%b required 0", imem_req_valid);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || inst_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL rdw_resume: req=%b addr=%h inst_valid=%b required 1 00000100 0",
               imem_req_valid, imem_req_addr, inst_valid);
    end
    lat_min = 0;
    lat_max = 0;
    wait_valid(10, ok, n);
    tests_run++;
    if (!ok || inst_pc !== 32'h100 || inst !== mem_data(32'h100)) begin
      fail_count++;
      $display("FAIL rdw_inst: ok=%b pc=%h inst=%h required 00000100 %h", ok, inst_pc, inst, mem_data(32'h100));
    end
  endtask

  task automatic test_redirect_coincident;
    bit ok;
    int n;
    wait_hs(20, ok);
    pulse_redirect(32'h200);
    @(negedge clk);
    tests_run++;
    if (!ok || inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      fail_count++;
      $display("FAIL rdc_nodrain: ok=%b inst_valid=%b req=%b addr=%h required 1 0 1 00000200",
               ok, inst_valid, imem_req_valid, imem_req_addr);
    end
    wait_valid(10, ok, n);
    tests_run++;
    if (!ok || inst_pc !== 32'h200 || inst !== mem_data(32'h200)) begin
      fail_count++;
      $display("FAIL rdc_inst: ok=%b pc=%h inst=%h required 00000200 %h", ok, inst_pc, inst, mem_data(32'h200));
    end
  endtask

  task automatic test_fault;
    bit ok;
    int n;
    fault_en   = 1'b1;
    fault_addr = 32'h8;
    pulse_redirect(32'h0);
    for (int k = 0; k < 3; k++) begin
      wait_valid(10, ok, n);
      tests_run++;
      if (!ok || inst_pc !== 32'(4 * k) || inst_fault !== (k == 2) || (k == 2 && inst !== 32'd0)) begin
        fail_count++;
        $display("FAIL fault_seq: ok=%b pc=%h inst=%h fault=%b required pc=%h fault=%b",
                 ok, inst_pc, inst, inst_fault, 32'(4 * k), (k == 2));
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b0) begin
        fail_count++;
        $display("FAIL fault_halt: req=%b required 0", imem_req_valid);
      end
    end
    fault_en = 1'b0;
    pulse_redirect(32'h20);
    wait_valid(10, ok, n);
    tests_run++;
    if (!ok || inst_pc !== 32'h20 || inst_fault !== 1'b0 || inst !== mem_data(32'h20)) begin
      fail_count++;
      $display("FAIL fault_resume: ok=%b pc=%h fault=%b required 00000020 0", ok, inst_pc, inst_fault);
    end
  endtask

  task automatic test_misaligned;
    bit ok;
    int n;
    pulse_redirect(32'h102);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (imem_req_valid !== 1'b0) begin
        fail_count++;
        $display("FAIL mis_noreq: req=%b addr=%h required 0", imem_req_valid, imem_req_addr);
      end
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok || inst_fault !== 1'b1 || inst_pc !== 32'h102 || inst !== 32'd0) begin
      fail_count++;
      $display("FAIL mis_fault: ok=%b pc=%h inst=%h fault=%b required 00000102 0 1", ok, inst_pc, inst, inst_fault);
    end
    pulse_redirect(32'hFFFF_FFFC);
    wait_valid(10, ok, n);
    tests_run++;
    if (!ok || inst_pc !== 32'hFFFF_FFFC || inst !== mem_data(32'hFFFF_FFFC) ||
        imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      fail_count++;
      $display("FAIL wrap: ok=%b pc=%h req=%b addr=%h required fffffffc 1 00000000",
               ok, inst_pc, imem_req_valid, imem_req_addr);
    end
    wait_valid(10, ok, n);
    tests_run++;
    if (!ok || inst_pc !== 32'h0 || inst !== mem_data(32'h0)) begin
      fail_count++;
      $display("FAIL wrap_inst: ok=%b pc=%h required 00000000", ok, inst_pc);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    wait_hs(20, ok);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (!ok || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0 || inst_fault !== 1'b0 ||
        imem_req_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL mid_reset: ok=%b valid=%b inst=%h pc=%h fault=%b req=%b required 1 and all 0",
               ok, inst_valid, inst, inst_pc, inst_fault, imem_req_valid);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL mid_first_early: req=%b required 0", imem_req_valid);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      fail_count++;
      $display("FAIL mid_first_req: req=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
    wait_valid(10, ok, n);
    tests_run++;
    if (!ok || inst_pc !== RST_PC || inst !== mem_data(RST_PC)) begin
      fail_count++;
      $display("FAIL mid_first_inst: ok=%b pc=%h inst=%h required %h %h", ok, inst_pc, inst, RST_PC, mem_data(RST_PC));
    end
  endtask

  task automatic test_random;
    int c0;
    logic [31:0] target;
    c0       = consumed;
    rdy_rand = 1'b1;
    lat_min  = 0;
    lat_max  = 3;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (redirect_valid) begin
        redirect_valid = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        target = 32'($urandom_range(0, 255)) * 32'd4;
        if ($urandom_range(0, 7) == 0) target = target + 32'd2;
        fault_en = ($urandom_range(0, 2) == 0);
        fault_addr = target + 32'($urandom_range(0, 5)) * 32'd4;
        redirect_valid = 1'b1;
        redirect_pc    = target;
      end
      inst_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    fault_en       = 1'b0;
    inst_ready     = 1'b1;
    rdy_rand       = 1'b0;
    lat_max        = 0;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    repeat (20) @(posedge clk);
    tests_run++;
    if (consumed - c0 < 15) begin
      fail_count++;
      $display("FAIL random_progress: consumed=%0d required at least 15", consumed - c0);
    end
  endtask

  initial begin
    mem_key = $urandom;
    test_reset;
    test_sequential;
    test_backpressure;
    test_redirect_wait;
    test_redirect_coincident;
    test_fault;
    test_misaligned;
    test_reset_mid;
    test_random;
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin
    #400000;
    fail_count++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
